dma_xfer_engine: RTL and testbench
==================================

Name: dma_xfer_engine

Overview:
- Transfer sequencer of the DMA controller; sits directly downstream of the configuration registers (source, destination, length).
- On a start pulse it latches the register outputs.
- It then moves a block of 16-bit words memory-to-memory over a single-outstanding req/ack master port, one read followed by one write per word.
- Reports busy, done and abort status back to the register side.

Parameters:
- ADDR_W, 16, width of byte addresses on the memory port
- DATA_W, 16, width of a transfer word
- CNT_W, 16, width of the word-count register
- ADDR_INC, 2, byte increment applied to src/dst after each word

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  one-cycle pulse; begins a transfer when idle
- abort  input  1  one-cycle pulse; stops the transfer after the current access
- cfg_src  input  ADDR_W  source byte address (configuration register output)
- cfg_dst  input  ADDR_W  destination byte address (configuration register output)
- cfg_len  input  CNT_W  number of words to move
- mem_req  output  1  access request, registered
- mem_we  output  1  1=write, 0=read, registered
- mem_addr  output  ADDR_W  access address, registered
- mem_wdata  output  DATA_W  write data, registered
- mem_rdata  input  DATA_W  read data, valid when mem_ack=1 on a read
- mem_ack  input  1  access complete; sampled only while mem_req=1
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse on normal completion
- aborted  output  1  sticky; set on abort completion, cleared by the next accepted start
- remaining  output  CNT_W  words still to move

Behaviour:
- Reset (async, immediate): all outputs 0; state IDLE; internal src/dst/count/data buffer 0; abort_pending 0.
- States: IDLE, RD, WR.
- IDLE:
  - start=1 and abort=0: latch cfg_src, cfg_dst, cfg_len; clear aborted.
  - If cfg_len==0: done=1 for the next cycle only, stay IDLE, no bus activity.
  - Otherwise, next edge: state RD, busy=1, mem_req=1, mem_we=0, mem_addr=src, remaining=cfg_len.
  - start and abort both 1 in IDLE: abort wins, start is ignored, aborted is unchanged.
- RD:
  - mem_req, mem_addr and mem_we stay stable until mem_ack.
  - On ack: capture mem_rdata into the buffer.
  - If abort_pending: go IDLE, mem_req=0, busy=0, aborted=1.
  - Otherwise, next edge: state WR, mem_we=1, mem_addr=dst, mem_wdata=buffer; mem_req stays 1 (back-to-back accesses are allowed).
- WR:
  - Hold until mem_ack.
  - On ack: src+=ADDR_INC, dst+=ADDR_INC (modulo 2^ADDR_W, wrap silently), remaining-=1.
  - If the new remaining==0: go IDLE, mem_req=0, mem_we=0, busy=0, done=1 for one cycle.
  - Else if abort_pending: go IDLE, aborted=1, no done.
  - Else: go RD with mem_addr=new src.
- abort while busy:
  - Sets abort_pending.
  - The current access always completes (its ack is awaited); abort_pending is cleared on entry to IDLE.
  - An abort arriving in the same cycle as the final WR ack: completion wins, so done=1 and aborted stays 0.
- start while busy: ignored. cfg_* changes while busy have no effect, because the values were latched.
- Timing:
  - Minimum of 2 cycles per word with zero-wait ack (ack in the same cycle as req).
  - First mem_req appears 1 cycle after the start edge.
  - done occurs 1 cycle after the last write ack.
- remaining is stable in IDLE; after abort it holds the count of unmoved words.
- mem_wdata holds its last value outside writes.

Test Plan:
- Reset mid-transfer: assert rst during WR of word 2 -> mem_req, busy, done, remaining all 0 immediately; no further accesses.
- Normal copy: src=0x0200, dst=0x0400, len=3, zero-wait ack, memory 0x0200..0x0204 = 0x1111,0x2222,0x3333 -> reads at 0x0200, 0x0202, 0x0204; writes 0x1111@0x0400, 0x2222@0x0402, 0x3333@0x0404; done pulse 7 cycles after start; busy high for 6 cycles.
- len=0: start -> done for one cycle on the next edge, mem_req never asserted, busy stays 0.
- Wait states and wrap: src=0xFFFE, dst=0x0010, len=2, ack delayed 3 cycles -> mem_req/mem_addr held stable until ack; second read at 0x0000; writes to 0x0010 and 0x0012.
- Abort: len=5, abort during RD of word 2 -> that read completes, no write to dst+2, aborted=1, done=0, remaining=4; a subsequent start clears aborted.
- Simultaneous events: start+abort in IDLE -> no transfer; abort in the cycle of the final write ack -> done=1, aborted=0; start pulse while busy -> ignored, transfer unaltered.

Source files
------------

// File: rtl/dma_xfer_engine.sv
// rtl/dma_xfer_engine.sv - DMA transfer sequencer: latched block copy over a single-outstanding req/ack port
module dma_xfer_engine #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 16,
  parameter int ADDR_INC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [CNT_W-1:0]  cfg_len,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  remaining
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(ADDR_INC);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_q, req_d, we_q, we_d, busy_q, busy_d;
  logic              done_q, done_d, aborted_q, aborted_d, pend_q, pend_d;
  logic              abort_now;
  logic [ADDR_W-1:0] src_nxt, dst_nxt;

  // An abort arriving in the same cycle as an ack counts as already pending.
  assign abort_now = pend_q | abort;
  assign src_nxt   = src_q + INC;
  assign dst_nxt   = dst_q + INC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      req_q     <= req_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    req_d     = req_q;
    we_d      = we_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    pend_d    = pend_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          src_d     = cfg_src;
          dst_d     = cfg_dst;
          cnt_d     = cfg_len;
          aborted_d = 1'b0;
          if (cfg_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RD;
            busy_d  = 1'b1;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = cfg_src;
          end
        end
      end
      RD: begin
        pend_d = abort_now;
        if (mem_ack) begin
          if (abort_now) begin
            state_d   = IDLE;
            req_d     = 1'b0;
            busy_d    = 1'b0;
            aborted_d = 1'b1;
            pend_d    = 1'b0;
          end else begin
            // The write-data register doubles as the read buffer.
            state_d = WR;
            we_d    = 1'b1;
            addr_d  = dst_q;
            wdata_d = mem_rdata;
          end
        end
      end
      WR: begin
        pend_d = abort_now;
        if (mem_ack) begin
          src_d  = src_nxt;
          dst_d  = dst_nxt;
          cnt_d  = cnt_q - 1'b1;
          we_d   = 1'b0;
          pend_d = 1'b0;
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            req_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (abort_now) begin
            state_d   = IDLE;
            req_d     = 1'b0;
            busy_d    = 1'b0;
            aborted_d = 1'b1;
          end else begin
            state_d = RD;
            addr_d  = src_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign remaining = cnt_q;

endmodule

// File: tb/tb_dma_xfer_engine.sv
// tb/tb_dma_xfer_engine.sv - directed self-checking bench for dma_xfer_engine
module tb_dma_xfer_engine;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] cfg_src, cfg_dst, cfg_len;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, remaining;
  logic        busy, done, aborted;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:32767];
  int          ack_delay = 0;
  int          wait_cnt;
  logic [15:0] rd_log[$];
  logic [15:0] wa_log[$];
  logic [15:0] wd_log[$];

  dma_xfer_engine dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .aborted(aborted), .remaining(remaining)
  );

  always #5 clk = ~clk;

  // Memory model: ack after ack_delay wait cycles, reads served from mem[], accesses logged.
  always_comb mem_ack   = mem_req && (wait_cnt == ack_delay);
  always_comb mem_rdata = mem[mem_addr[15:1]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 0;
    end else begin
      if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
      else                     wait_cnt <= 0;
      if (mem_req && mem_ack) begin
        if (mem_we) begin
          wa_log.push_back(mem_addr);
          wd_log.push_back(mem_wdata);
        end else begin
          rd_log.push_back(mem_addr);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted: got %b expected 0", aborted); end
    checks++; if (remaining !== 16'h0) begin errors++; $display("FAIL reset_remaining: got %h expected 0000", remaining); end
    checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_bus: got addr %h wdata %h we %b expected 0", mem_addr, mem_wdata, mem_we);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL reset_release: got busy %b req %b expected 0", busy, mem_req); end
  endtask

  task automatic test_normal();
    int rb, wb, busy_cnt, done_cnt, done_at;
    logic [15:0] er [3];
    logic [15:0] ew [3];
    logic [15:0] ed [3];
    logic [15:0] got;
    er[0] = 16'h0200; er[1] = 16'h0202; er[2] = 16'h0204;
    ew[0] = 16'h0400; ew[1] = 16'h0402; ew[2] = 16'h0404;
    ed[0] = 16'h1111; ed[1] = 16'h2222; ed[2] = 16'h3333;
    rb = rd_log.size(); wb = wa_log.size();
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    ack_delay = 0;
    @(negedge clk);
    cfg_src = 16'h0200; cfg_dst = 16'h0400; cfg_len = 16'd3; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; if (done_at == 0) done_at = k; end
    end
    checks++; if (busy_cnt !== 6) begin errors++; $display("FAIL normal_busy_cycles: got %0d expected 6", busy_cnt); end
    checks++; if (done_at !== 7) begin errors++; $display("FAIL normal_done_time: got %0d expected 7", done_at); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL normal_done_width: got %0d expected 1", done_cnt); end
    checks++; if (rd_log.size() - rb !== 3 || wa_log.size() - wb !== 3) begin
      errors++; $display("FAIL normal_access_count: got %0d reads %0d writes expected 3 3", rd_log.size() - rb, wa_log.size() - wb);
    end
    for (int i = 0; i < 3; i++) begin
      got = (rb + i < rd_log.size()) ? rd_log[rb + i] : 16'hxxxx;
      checks++; if (got !== er[i]) begin errors++; $display("FAIL normal_rd_addr%0d: got %h expected %h", i, got, er[i]); end
      got = (wb + i < wa_log.size()) ? wa_log[wb + i] : 16'hxxxx;
      checks++; if (got !== ew[i]) begin errors++; $display("FAIL normal_wr_addr%0d: got %h expected %h", i, got, ew[i]); end
      got = (wb + i < wd_log.size()) ? wd_log[wb + i] : 16'hxxxx;
      checks++; if (got !== ed[i]) begin errors++; $display("FAIL normal_wr_data%0d: got %h expected %h", i, got, ed[i]); end
    end
    checks++; if (remaining !== 16'h0 || aborted !== 1'b0) begin
      errors++; $display("FAIL normal_final: got remaining %h aborted %b expected 0000 0", remaining, aborted);
    end
  endtask

  task automatic test_len0();
    int req_seen, busy_seen, done_cnt, done_at;
    req_seen = 0; busy_seen = 0; done_cnt = 0; done_at = 0;
    @(negedge clk);
    cfg_src = 16'h1234; cfg_dst = 16'h5678; cfg_len = 16'd0; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (mem_req) req_seen++;
      if (busy) busy_seen++;
      if (done) begin done_cnt++; if (done_at == 0) done_at = k; end
    end
    checks++; if (done_at !== 1) begin errors++; $display("FAIL len0_done_time: got %0d expected 1", done_at); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL len0_done_width: got %0d expected 1", done_cnt); end
    checks++; if (req_seen !== 0) begin errors++; $display("FAIL len0_no_req: got %0d expected 0", req_seen); end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL len0_no_busy: got %0d expected 0", busy_seen); end
  endtask

  task automatic test_wait_wrap();
    int rb, wb, busy_cnt, unstable, done_cnt;
    logic        prev_hold, prev_we;
    logic [15:0] prev_addr, got;
    rb = rd_log.size(); wb = wa_log.size();
    busy_cnt = 0; unstable = 0; done_cnt = 0; prev_hold = 1'b0; prev_we = 1'b0; prev_addr = 16'h0;
    ack_delay = 3;
    @(negedge clk);
    cfg_src = 16'hFFFE; cfg_dst = 16'h0010; cfg_len = 16'd2; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (prev_hold && (!mem_req || mem_addr !== prev_addr || mem_we !== prev_we)) unstable++;
      prev_hold = mem_req && !mem_ack; prev_addr = mem_addr; prev_we = mem_we;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    ack_delay = 0;
    checks++; if (unstable !== 0) begin errors++; $display("FAIL wait_stable: got %0d changes expected 0", unstable); end
    checks++; if (busy_cnt !== 16) begin errors++; $display("FAIL wait_busy_cycles: got %0d expected 16", busy_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL wait_done: got %0d expected 1", done_cnt); end
    got = (rb + 0 < rd_log.size()) ? rd_log[rb + 0] : 16'hxxxx;
    checks++; if (got !== 16'hFFFE) begin errors++; $display("FAIL wait_rd0: got %h expected fffe", got); end
    got = (rb + 1 < rd_log.size()) ? rd_log[rb + 1] : 16'hxxxx;
    checks++; if (got !== 16'h0000) begin errors++; $display("FAIL wait_rd1_wrap: got %h expected 0000", got); end
    got = (wb + 0 < wa_log.size()) ? wa_log[wb + 0] : 16'hxxxx;
    checks++; if (got !== 16'h0010) begin errors++; $display("FAIL wait_wr0: got %h expected 0010", got); end
    got = (wb + 1 < wa_log.size()) ? wa_log[wb + 1] : 16'hxxxx;
    checks++; if (got !== 16'h0012) begin errors++; $display("FAIL wait_wr1: got %h expected 0012", got); end
    got = (wb + 1 < wd_log.size()) ? wd_log[wb + 1] : 16'hxxxx;
    checks++; if (got !== 16'hBBBB) begin errors++; $display("FAIL wait_wr1_data: got %h expected bbbb", got); end
  endtask

  task automatic test_abort();
    int rb, wb, found, done_cnt, req_seen;
    logic [15:0] got;
    rb = rd_log.size(); wb = wa_log.size(); found = 0; done_cnt = 0; req_seen = 0;
    @(negedge clk);
    cfg_src = 16'h0600; cfg_dst = 16'h0800; cfg_len = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      if (mem_req && !mem_we && mem_addr == 16'h0602) found = 1;
      else @(negedge clk);
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL abort_reach_rd2: got %0d expected 1", found); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %b expected 0", busy); end
    checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_flag: got %b expected 1", aborted); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
    checks++; if (remaining !== 16'd4) begin errors++; $display("FAIL abort_remaining: got %0d expected 4", remaining); end
    checks++; if (rd_log.size() - rb !== 2 || wa_log.size() - wb !== 1) begin
      errors++; $display("FAIL abort_accesses: got %0d reads %0d writes expected 2 1", rd_log.size() - rb, wa_log.size() - wb);
    end
    got = (rb + 1 < rd_log.size()) ? rd_log[rb + 1] : 16'hxxxx;
    checks++; if (got !== 16'h0602) begin errors++; $display("FAIL abort_rd2_done: got %h expected 0602", got); end
    // start and abort together while idle: nothing latched, sticky flag untouched
    cfg_src = 16'h0A00; cfg_dst = 16'h0B00; cfg_len = 16'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (mem_req || busy || done) req_seen++;
      @(negedge clk);
    end
    checks++; if (req_seen !== 0) begin errors++; $display("FAIL idle_start_abort_activity: got %0d expected 0", req_seen); end
    checks++; if (aborted !== 1'b1 || remaining !== 16'd4) begin
      errors++; $display("FAIL idle_start_abort_state: got aborted %b remaining %0d expected 1 4", aborted, remaining);
    end
    cfg_len = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL abort_cleared_by_start: got %b expected 0", aborted); end
  endtask

  task automatic test_simultaneous();
    int rb, wb, found, busy_cnt;
    logic [15:0] got;
    found = 0;
    @(negedge clk);
    cfg_src = 16'h0100; cfg_dst = 16'h0300; cfg_len = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      if (mem_req && mem_we && remaining == 16'd1) found = 1;
      else @(negedge clk);
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL final_wr_reach: got %0d expected 1", found); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (done !== 1'b1 || aborted !== 1'b0) begin
      errors++; $display("FAIL final_ack_abort: got done %b aborted %b expected 1 0", done, aborted);
    end
    checks++; if (remaining !== 16'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL final_ack_state: got remaining %h busy %b expected 0000 0", remaining, busy);
    end
    // start pulse with changed cfg while busy must not disturb the running copy
    rb = rd_log.size(); wb = wa_log.size(); busy_cnt = 0;
    @(negedge clk);
    cfg_src = 16'h0000; cfg_dst = 16'h0700; cfg_len = 16'd2; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 2) begin cfg_src = 16'h1000; cfg_dst = 16'h2000; cfg_len = 16'd9; start = 1'b1; end
      if (k == 3) start = 1'b0;
      if (busy) busy_cnt++;
    end
    checks++; if (busy_cnt !== 4) begin errors++; $display("FAIL busy_start_cycles: got %0d expected 4", busy_cnt); end
    checks++; if (rd_log.size() - rb !== 2 || wa_log.size() - wb !== 2) begin
      errors++; $display("FAIL busy_start_accesses: got %0d reads %0d writes expected 2 2", rd_log.size() - rb, wa_log.size() - wb);
    end
    got = (wb + 1 < wa_log.size()) ? wa_log[wb + 1] : 16'hxxxx;
    checks++; if (got !== 16'h0702) begin errors++; $display("FAIL busy_start_wr1: got %h expected 0702", got); end
    got = (wb + 1 < wd_log.size()) ? wd_log[wb + 1] : 16'hxxxx;
    checks++; if (got !== 16'hC0DE) begin errors++; $display("FAIL busy_start_data1: got %h expected c0de", got); end
    checks++; if (remaining !== 16'h0) begin errors++; $display("FAIL busy_start_remaining: got %h expected 0000", remaining); end
  endtask

  task automatic test_reset_mid();
    int found, rn, wn, req_seen;
    found = 0; req_seen = 0;
    @(negedge clk);
    cfg_src = 16'h0200; cfg_dst = 16'h0A00; cfg_len = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      if (mem_req && mem_we && remaining == 16'd2) found = 1;
      else @(negedge clk);
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL mid_reach_wr2: got %0d expected 1", found); end
    #1 rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || remaining !== 16'h0) begin
      errors++; $display("FAIL mid_reset_async: got req %b busy %b done %b remaining %h expected 0 0 0 0000", mem_req, busy, done, remaining);
    end
    rn = rd_log.size(); wn = wa_log.size();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_req || busy) req_seen++;
    end
    checks++; if (req_seen !== 0) begin errors++; $display("FAIL mid_reset_quiet: got %0d active cycles expected 0", req_seen); end
    checks++; if (rd_log.size() !== rn || wa_log.size() !== wn) begin
      errors++; $display("FAIL mid_reset_accesses: got %0d/%0d expected %0d/%0d", rd_log.size(), wa_log.size(), rn, wn);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_src = 16'h0; cfg_dst = 16'h0; cfg_len = 16'h0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0;
    mem[16'h0100] = 16'h1111; mem[16'h0101] = 16'h2222; mem[16'h0102] = 16'h3333;
    mem[16'h7FFF] = 16'hAAAA; mem[16'h0000] = 16'hBBBB; mem[16'h0001] = 16'hC0DE;
    mem[16'h0300] = 16'h5A01; mem[16'h0301] = 16'h5A02;
    #2;
    test_reset();
    test_normal();
    test_len0();
    test_wait_wrap();
    test_abort();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
